mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one memory arbiter that shares the single instruction/data RAM port between the instruction fetch unit (port `i_`) and the load/store unit (port `d_`). It sits between both requesters and the RAM, forwards one request per cycle using the codebase's req/addr_ok/data_ok handshake, and tracks outstanding transactions in an in-order ID FIFO so each response is routed back to its issuer. Priority goes to the data port, with a starvation counter that guarantees instruction fetch progress.

## Interface
- `OUTSTANDING`, 2: max accepted-but-unanswered transactions (ID FIFO depth, power of two, ≥1).
- `STARVE_LIMIT`, 4: consecutive rejected IFU-request cycles before IFU gets priority (≥1).
- Data/address width is `` `XLEN`` from config.svh; strobe width `` `XLEN/8``.
- `clk` in 1: single clock, all state on rising edge.
- `rst_b` in 1: reset, synchronous, active-low.
- `i_req`, `i_write`, `i_wstrb`, `i_addr`, `i_wdata` in 1/1/XLEN/8/XLEN/XLEN: IFU request.
- `i_addr_ok` out 1: IFU request accepted this cycle.
- `i_data_ok` out 1: IFU response valid this cycle.
- `i_rdata` out XLEN: IFU read data.
- `d_req`, `d_write`, `d_wstrb`, `d_addr`, `d_wdata`, `d_addr_ok`, `d_data_ok`, `d_rdata`: same as `i_` for LSU.
- `ram_req`, `ram_write`, `ram_wstrb`, `ram_addr`, `ram_wdata` out: request to RAM (muxed from granted port).
- `ram_addr_ok` in 1: RAM accepts request this cycle.
- `ram_data_ok` in 1: RAM response valid (reads and writes), in request order.
- `ram_rdata` in XLEN: RAM read data.
- `resp_err` out 1: sticky; set by a RAM response with no outstanding transaction.

## Operation
- Grant (combinational): if `i_req` and `starve_cnt == STARVE_LIMIT` -> IFU; else if `d_req` -> LSU; else if `i_req` -> IFU; else none.
- `ram_req` = granted port's req AND FIFO not full AND not in reset. `ram_write/wstrb/addr/wdata` = granted port's fields (LSU fields when none granted).
- Accept = `ram_req && ram_addr_ok`; granted port's `addr_ok` = accept; other port's `addr_ok` = 0.
- On accept: push ID (0 = IFU, 1 = LSU) into FIFO.
- On `ram_data_ok` with FIFO non-empty: pop; `i_data_ok` = 1 if head ID 0, else `d_data_ok` = 1. `ram_rdata` driven to both `i_rdata` and `d_rdata`.
- `ram_data_ok` with FIFO empty: no pop, no upstream data_ok, `resp_err` <= 1 (cleared only by reset).
- Full check uses registered count only: when full, no push even if a pop occurs the same cycle. Push and pop in the same non-full cycle: count unchanged.
- Starvation counter (width clog2(STARVE_LIMIT+1)): cleared when IFU accepted or `i_req` = 0; else incremented while `i_req` high and not accepted; saturates at STARVE_LIMIT.
- Writes occupy a FIFO slot and complete on their `data_ok` like reads.

## Timing
- Reset values: FIFO empty (count 0, pointers 0), `starve_cnt` 0, `resp_err` 0; all `addr_ok`, `data_ok`, `ram_req` forced 0 while `rst_b` = 0.
- Reset mid-operation discards all outstanding IDs; RAM must be reset concurrently, else late responses set `resp_err`.
- Zero added latency: `ram_addr_ok` -> `*_addr_ok` and `ram_data_ok` -> `*_data_ok` are combinational same-cycle paths.
- Throughput: one accept per cycle while FIFO not full; with 1-cycle RAM and OUTSTANDING ≥ 2, back-to-back accepts sustain indefinitely.
- Requester must hold req/fields stable until `addr_ok`; arbiter does not register requests.
- Worst-case IFU wait under continuous LSU traffic: STARVE_LIMIT cycles plus FIFO-full stalls.

## Test plan
- IFU only, 1-cycle RAM: fetch 0x0, 0x4, 0x8 on consecutive cycles -> `i_addr_ok` each cycle, `i_data_ok` on next three cycles with matching data, `d_data_ok` never 1.
- Both request same cycle (i addr 0x100, d load 0x2000) -> d accepted first, IFU accepted next cycle; responses routed d then i.
- STARVE_LIMIT=4, `d_req` held high, `i_req` high from cycle 0 -> d accepted cycles 0–3, IFU accepted cycle 4, d resumes cycle 5; counter back to 0.
- OUTSTANDING=2, RAM withholds `ram_data_ok`, `ram_addr_ok`=1 -> two accepts, third cycle `ram_req`=0 and both `addr_ok`=0; one response frees slot next cycle.
- Interleaved I, D(write), I accepted, RAM responds 3 cycles later in order -> `i_data_ok`, `d_data_ok`, `i_data_ok` in that order.
- `ram_data_ok` pulse with FIFO empty -> no upstream data_ok, `resp_err`=1 held; `rst_b`=0 one cycle clears it to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one RAM request port between IFU and LSU, with an
// in-order ID FIFO that routes each RAM response back to the port that issued it.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,

  input  logic                  i_req,
  input  logic                  i_write,
  input  logic [`XLEN/8-1:0]    i_wstrb,
  input  logic [`XLEN-1:0]      i_addr,
  input  logic [`XLEN-1:0]      i_wdata,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  output logic [`XLEN-1:0]      i_rdata,

  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [`XLEN/8-1:0]    d_wstrb,
  input  logic [`XLEN-1:0]      d_addr,
  input  logic [`XLEN-1:0]      d_wdata,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic [`XLEN-1:0]      d_rdata,

  output logic                  ram_req,
  output logic                  ram_write,
  output logic [`XLEN/8-1:0]    ram_wstrb,
  output logic [`XLEN-1:0]      ram_addr,
  output logic [`XLEN-1:0]      ram_wdata,
  input  logic                  ram_addr_ok,
  input  logic                  ram_data_ok,
  input  logic [`XLEN-1:0]      ram_rdata,

  output logic                  resp_err
);

  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GNT_NONE, GNT_IFU, GNT_LSU} grant_t;
  typedef enum logic {ID_IFU = 1'b0, ID_LSU = 1'b1} id_t;

  grant_t          grant;
  id_t             id_mem [OUTSTANDING];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic            full, empty, accept, push, pop;
  id_t             head_id;

  assign full    = (count == CW'(OUTSTANDING));
  assign empty   = (count == '0);
  assign head_id = id_mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    // Explicit wrap keeps OUTSTANDING == 1 (single-entry FIFO) well defined.
    if (p == PW'(OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    grant = GNT_NONE;
    if (i_req && starve_cnt == SW'(STARVE_LIMIT)) grant = GNT_IFU;
    else if (d_req)                               grant = GNT_LSU;
    else if (i_req)                               grant = GNT_IFU;
  end

  always_comb begin
    ram_write = d_write;
    ram_wstrb = d_wstrb;
    ram_addr  = d_addr;
    ram_wdata = d_wdata;
    if (grant == GNT_IFU) begin
      ram_write = i_write;
      ram_wstrb = i_wstrb;
      ram_addr  = i_addr;
      ram_wdata = i_wdata;
    end
  end

  assign ram_req   = rst_b && !full && (grant != GNT_NONE);
  assign accept    = ram_req && ram_addr_ok;
  assign i_addr_ok = accept && (grant == GNT_IFU);
  assign d_addr_ok = accept && (grant == GNT_LSU);

  assign push      = accept;
  assign pop       = rst_b && ram_data_ok && !empty;
  assign i_data_ok = pop && (head_id == ID_IFU);
  assign d_data_ok = pop && (head_id == ID_LSU);
  assign i_rdata   = ram_rdata;
  assign d_rdata   = ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned k = 0; k < OUTSTANDING; k++) id_mem[k] <= ID_IFU;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= (grant == GNT_LSU) ? ID_LSU : ID_IFU;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      starve_cnt <= '0;
    end else if (!i_req || i_addr_ok) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b)                    resp_err <= 1'b0;
    else if (ram_data_ok && empty) resp_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vectors for mem_arbiter (OUTSTANDING=2, STARVE_LIMIT=4);
// inputs are driven on the falling edge and combinational outputs checked 1ns later.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;

  logic                 clk;
  logic                 rst_b;
  logic                 i_req, i_write;
  logic [`XLEN/8-1:0]   i_wstrb;
  logic [`XLEN-1:0]     i_addr, i_wdata, i_rdata;
  logic                 i_addr_ok, i_data_ok;
  logic                 d_req, d_write;
  logic [`XLEN/8-1:0]   d_wstrb;
  logic [`XLEN-1:0]     d_addr, d_wdata, d_rdata;
  logic                 d_addr_ok, d_data_ok;
  logic                 ram_req, ram_write;
  logic [`XLEN/8-1:0]   ram_wstrb;
  logic [`XLEN-1:0]     ram_addr, ram_wdata, ram_rdata;
  logic                 ram_addr_ok, ram_data_ok;
  logic                 resp_err;

  int tests  = 0;
  int errors = 0;

  mem_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_write(i_write), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .ram_req(ram_req), .ram_write(ram_write), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok),
    .ram_rdata(ram_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // exp flags: {ram_req, ram_write, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, resp_err}
  typedef struct {
    logic             rst;
    logic             ireq;
    logic             iwr;
    logic [`XLEN-1:0] iaddr;
    logic             dreq;
    logic             dwr;
    logic [`XLEN-1:0] daddr;
    logic             aok;
    logic             dok;
    logic [`XLEN-1:0] rdata;
    logic [6:0]       exp;
    logic [`XLEN-1:0] exp_addr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic ireq, input logic iwr,
                              input logic [`XLEN-1:0] iaddr, input logic dreq, input logic dwr,
                              input logic [`XLEN-1:0] daddr, input logic aok, input logic dok,
                              input logic [`XLEN-1:0] rdata, input logic [6:0] exp,
                              input logic [`XLEN-1:0] exp_addr);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iwr = iwr; v.iaddr = iaddr;
    v.dreq = dreq; v.dwr = dwr; v.daddr = daddr; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.exp = exp; v.exp_addr = exp_addr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_b       = v.rst;
    i_req       = v.ireq;
    i_write     = v.iwr;
    i_addr      = v.iaddr;
    d_req       = v.dreq;
    d_write     = v.dwr;
    d_addr      = v.daddr;
    ram_addr_ok = v.aok;
    ram_data_ok = v.dok;
    ram_rdata   = v.rdata;
  endtask

  task automatic check(input string name, input logic [6:0] exp, input logic [`XLEN-1:0] exp_addr,
                       input logic [`XLEN-1:0] exp_rdata);
    logic [6:0] got;
    got = {ram_req, ram_write, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, resp_err};
    tests++;
    if (got !== exp || ram_addr !== exp_addr || i_rdata !== exp_rdata || d_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s: got flags=%b addr=%h i_rdata=%h d_rdata=%h, expected flags=%b addr=%h rdata=%h",
               name, got, ram_addr, i_rdata, d_rdata, exp, exp_addr, exp_rdata);
    end
  endtask

  initial begin
    i_wstrb = '0; i_wdata = 32'h0000_AAAA;
    d_wstrb = '1; d_wdata = 32'h0000_BBBB;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0, 0));
    repeat (2) @(posedge clk);

    // reset: outputs gated even with requests and RAM strobes active
    vq.push_back(mk(0, 1, 0, 'h0,   1, 0, 'h2000, 1, 1, 'h0,  7'b0000000, 'h2000));
    // IFU-only stream, 1-cycle RAM
    vq.push_back(mk(1, 1, 0, 'h0,   0, 0, 'h2000, 1, 0, 'h0,  7'b1010000, 'h0));
    vq.push_back(mk(1, 1, 0, 'h4,   0, 0, 'h2000, 1, 1, 'h11, 7'b1010100, 'h4));
    vq.push_back(mk(1, 1, 0, 'h8,   0, 0, 'h2000, 1, 1, 'h22, 7'b1010100, 'h8));
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h2000, 1, 1, 'h33, 7'b0000100, 'h2000));
    // simultaneous requests: LSU first, IFU next cycle, responses D then I
    vq.push_back(mk(1, 1, 0, 'h100, 1, 0, 'h2000, 1, 0, 'h0,  7'b1001000, 'h2000));
    vq.push_back(mk(1, 1, 0, 'h100, 0, 0, 'h2000, 1, 1, 'h44, 7'b1010010, 'h100));
    vq.push_back(mk(1, 0, 0, 'h100, 0, 0, 'h2000, 1, 1, 'h55, 7'b0000100, 'h2000));
    // starvation: LSU wins 4 cycles, IFU on the 5th, LSU resumes
    vq.push_back(mk(1, 1, 0, 'h200, 1, 0, 'h3000, 1, 0, 'h0,  7'b1001000, 'h3000));
    vq.push_back(mk(1, 1, 0, 'h200, 1, 0, 'h3000, 1, 1, 'h61, 7'b1001010, 'h3000));
    vq.push_back(mk(1, 1, 0, 'h200, 1, 0, 'h3000, 1, 1, 'h62, 7'b1001010, 'h3000));
    vq.push_back(mk(1, 1, 0, 'h200, 1, 0, 'h3000, 1, 1, 'h63, 7'b1001010, 'h3000));
    vq.push_back(mk(1, 1, 0, 'h200, 1, 0, 'h3000, 1, 1, 'h64, 7'b1010010, 'h200));
    vq.push_back(mk(1, 1, 0, 'h200, 1, 0, 'h3000, 1, 1, 'h65, 7'b1001100, 'h3000));
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h3000, 1, 1, 'h66, 7'b0000010, 'h3000));
    // FIFO full: two accepts, then stall; a pop while full still blocks the push
    vq.push_back(mk(1, 0, 0, 'h0,   1, 0, 'h3000, 1, 0, 'h0,  7'b1001000, 'h3000));
    vq.push_back(mk(1, 0, 0, 'h0,   1, 0, 'h3000, 1, 0, 'h0,  7'b1001000, 'h3000));
    vq.push_back(mk(1, 1, 0, 'h300, 1, 0, 'h3000, 1, 0, 'h0,  7'b0000000, 'h3000));
    vq.push_back(mk(1, 1, 0, 'h300, 1, 0, 'h3000, 1, 1, 'h67, 7'b0000010, 'h3000));
    vq.push_back(mk(1, 1, 0, 'h300, 1, 0, 'h3004, 1, 0, 'h0,  7'b1001000, 'h3004));
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h2000, 1, 1, 'h68, 7'b0000010, 'h2000));
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h2000, 1, 1, 'h69, 7'b0000010, 'h2000));
    // interleaved I, D write, I with delayed in-order responses
    vq.push_back(mk(1, 1, 0, 'h10,  0, 0, 'h2000, 1, 0, 'h0,  7'b1010000, 'h10));
    vq.push_back(mk(1, 0, 0, 'h0,   1, 1, 'h4000, 1, 0, 'h0,  7'b1101000, 'h4000));
    vq.push_back(mk(1, 1, 0, 'h14,  0, 0, 'h2000, 1, 0, 'h0,  7'b0000000, 'h14));
    vq.push_back(mk(1, 1, 0, 'h14,  0, 0, 'h2000, 1, 1, 'h77, 7'b0000100, 'h14));
    vq.push_back(mk(1, 1, 0, 'h14,  0, 0, 'h2000, 1, 1, 'h78, 7'b1010010, 'h14));
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h2000, 1, 1, 'h79, 7'b0000100, 'h2000));
    // stray response with empty FIFO: sticky error, cleared by reset
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h2000, 1, 1, 'h7a, 7'b0000000, 'h2000));
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h2000, 1, 0, 'h0,  7'b0000001, 'h2000));
    vq.push_back(mk(0, 0, 0, 'h0,   0, 0, 'h2000, 1, 0, 'h0,  7'b0000001, 'h2000));
    vq.push_back(mk(1, 0, 0, 'h0,   0, 0, 'h2000, 1, 0, 'h0,  7'b0000000, 'h2000));

    foreach (vq[n]) begin
      @(negedge clk);
      drive(vq[n]);
      #1;
      check($sformatf("vec%0d", n), vq[n].exp, vq[n].exp_addr, vq[n].rdata);
    end

    // reset mid-operation drops the outstanding ID; the late response is an error
    @(negedge clk);
    drive(mk(1, 1, 0, 'h500, 0, 0, 'h2000, 1, 0, 'h0, 7'b0, 0));
    #1 check("midrst_accept", 7'b1010000, 'h500, 'h0);
    @(negedge clk);
    drive(mk(0, 1, 0, 'h500, 0, 0, 'h2000, 1, 0, 'h0, 7'b0, 0));
    #1 check("midrst_hold", 7'b0000000, 'h500, 'h0);
    @(negedge clk);
    drive(mk(1, 0, 0, 'h0, 0, 0, 'h2000, 1, 1, 'h88, 7'b0, 0));
    #1 check("midrst_late_resp", 7'b0000000, 'h2000, 'h88);
    @(negedge clk);
    drive(mk(1, 0, 0, 'h0, 0, 0, 'h2000, 1, 0, 'h0, 7'b0, 0));
    #1 check("midrst_err", 7'b0000001, 'h2000, 'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
